// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher.
//
// Contents:
//   aes_state_t       128-bit AES state; byte 0 in [127:120], column-major
//   aes_seq_state_e   sequencer FSM state encoding
//   AES_NR            number of AES-128 rounds
//   AES_KEY_IDX_W     width of the round-key index
//   inv_shift_rows / inv_sub_bytes / inv_mix_columns   inverse round steps
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_seq_state_e;

  localparam int unsigned AES_NR        = 10;
  localparam int unsigned AES_KEY_IDX_W = 4;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sub_byte(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Row r is rotated right by r columns.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sub_byte(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
      };
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
//
// Ports:
//   state_i       current state
//   round_key_i   round key for this round
//   last_round_i  high for the final round: InvMixColumns is skipped
//   state_o       next state
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         last_round_i,
  output logic [127:0] state_o
);

  aes_state_t sub_add;

  always_comb begin
    sub_add = inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i;
    state_o = last_round_i ? sub_add : inv_mix_columns(sub_add);
  end

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128 inverse-cipher sequencer: one inverse round per clock.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   in_valid_i/in_ready_o  ciphertext handshake, data_in_i
//   key_valid_i            external key schedule is complete
//   key_idx_o/round_key_i  round-key lookup (combinational, same cycle)
//   out_valid_o/out_ready_i plaintext handshake, data_out_o
//   busy_o                 a block is in flight or awaiting transfer
module aes_inv_cipher_seq
  import aes_pkg::*;
#(
  // Only AES-128 (10 rounds) is supported.
  parameter int unsigned NumRounds = AES_NR
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [127:0]             data_in_i,
  input  logic                     key_valid_i,
  output logic [AES_KEY_IDX_W-1:0] key_idx_o,
  input  logic [127:0]             round_key_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [127:0]             data_out_o,
  output logic                     busy_o
);

  localparam logic [1:0] StIdle  = 2'(IDLE);
  localparam logic [1:0] StRound = 2'(ROUND);
  localparam logic [1:0] StDone  = 2'(DONE);

  localparam logic [AES_KEY_IDX_W-1:0] LastKeyIdx  = AES_KEY_IDX_W'(NumRounds);
  localparam logic [AES_KEY_IDX_W-1:0] FirstRound  = AES_KEY_IDX_W'(NumRounds - 1);

  logic [1:0]               state_q, state_d;
  logic [AES_KEY_IDX_W-1:0] round_q, round_d;
  aes_state_t               data_q, data_d;
  aes_state_t               round_out;
  logic                     last_round;
  logic                     accept;

  assign last_round = (round_q == '0);

  aes_inv_round u_round (
    .state_i      (data_q),
    .round_key_i  (round_key_i),
    .last_round_i (last_round),
    .state_o      (round_out)
  );

  // Ready is masked during reset so no block is taken on the reset edge.
  assign in_ready_o  = (state_q == StIdle) && key_valid_i && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign data_out_o  = data_q;

  always_comb begin
    unique case (state_q)
      StIdle:  key_idx_o = LastKeyIdx;
      StRound: key_idx_o = round_q;
      default: key_idx_o = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = data_in_i ^ round_key_i;
          round_d = FirstRound;
          state_d = StRound;
        end
      end
      StRound: begin
        data_d = round_out;
        if (last_round) begin
          state_d = StDone;
        end else begin
          round_d = round_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Bench for aes_inv_cipher_seq. The reference model is a forward AES-128
// encryptor: random plaintexts are encrypted here, the DUT must recover them.
module tb_aes_inv_cipher_seq;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, key_valid, out_valid, out_ready, busy;
  logic [127:0] data_in, round_key, data_out;
  logic [3:0]   key_idx;

  logic [127:0] rk [16];
  logic [7:0]   sbox [256];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];

  aes_inv_cipher_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_in_i   (data_in),
    .key_valid_i (key_valid),
    .key_idx_o   (key_idx),
    .round_key_i (round_key),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_out_o  (data_out),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign round_key = rk[key_idx];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred/expired, expected otherwise", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= p;
      p = xt(p);
    end
    return r;
  endfunction

  // S-box by exhaustive search for the inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
                ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) rk[j] = '0;
    for (int j = 0; j < 11; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c + row] = t[4*((c + row) % 4) + row];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk[r][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    int a;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) flag("unexpected_out_valid");
        else begin
          a = acc_q.pop_front();
          check("latency", 128'(cyc - a), 128'd11);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) flag("unexpected_transfer");
        else check("plaintext", data_out, exp_q.pop_front());
      end
      ov_prev = out_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer ct until accepted; returns in cycle 1 after the accept edge.
  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit push,
                      output int acc_cyc, output int waited);
    bit got = 1'b0;
    data_in  = ct;
    in_valid = 1'b1;
    acc_cyc  = -1;
    waited   = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin
        check("accept_key_idx", 128'(key_idx), 128'd10);
        if (push) begin
          exp_q.push_back(pt);
          acc_q.push_back(cyc);
        end
        acc_cyc = cyc;
        waited  = n;
        got     = 1'b1;
      end
      tick();
    end
    if (!got) flag("accept_timeout");
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) flag("drain_timeout");
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] pt, ct, held;
    int a, w;
    int accs [3];
    bit seen;

    rst = 1'b1; in_valid = 1'b0; key_valid = 1'b1; out_ready = 1'b0; data_in = '0;
    build_sbox();
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    tick(); tick();
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_data_out", data_out, 128'd0);
    check("rst_key_idx", 128'(key_idx), 128'd10);
    tick();
    rst = 1'b0;

    // FIPS-197 C.1 with key-index sequence.
    out_ready = 1'b1;
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1'b1,
         a, w);
    in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("key_idx_seq", 128'(key_idx), (k <= 10) ? 128'(10 - k) : 128'd0);
    end
    drain();

    // Backpressure: 20 cycles with out_ready low.
    out_ready = 1'b0;
    pt = rand128();
    send(encrypt(pt), pt, 1'b1, a, w);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) flag("out_valid_timeout");
    held = data_out;
    check("bp_data", held, pt);
    tick();
    in_valid = 1'b1;
    data_in  = rand128();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_data_stable", data_out, held);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp_idle_busy", 128'(busy), 128'd0);
    check("bp_idle_out_valid", 128'(out_valid), 128'd0);
    tick();

    // Three back-to-back blocks.
    for (int i = 0; i < 3; i++) begin
      pt = rand128();
      send(encrypt(pt), pt, 1'b1, accs[i], w);
    end
    in_valid = 1'b0;
    check("b2b_spacing_1", 128'(accs[1] - accs[0]), 128'd12);
    check("b2b_spacing_2", 128'(accs[2] - accs[1]), 128'd12);
    drain();

    // KeyValid low blocks acceptance.
    key_valid = 1'b0;
    pt = rand128();
    data_in  = encrypt(pt);
    in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("nokey_in_ready", 128'(in_ready), 128'd0);
      check("nokey_busy", 128'(busy), 128'd0);
      tick();
    end
    key_valid = 1'b1;
    send(encrypt(pt), pt, 1'b1, a, w);
    in_valid = 1'b0;
    check("key_raise_wait", 128'(w), 128'd0);
    drain();

    // Reset during ROUND cycle 5 discards the block.
    pt = rand128();
    send(encrypt(pt), pt, 1'b0, a, w);
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_data_out", data_out, 128'd0);
    check("midrst_key_idx", 128'(key_idx), 128'd10);
    tick();
    repeat (14) tick();
    pt = rand128();
    send(encrypt(pt), pt, 1'b1, a, w);
    in_valid = 1'b0;
    drain();

    // InValid toggling with new data while busy is ignored.
    pt = rand128();
    send(encrypt(pt), pt, 1'b1, a, w);
    for (int n = 0; n < 10; n++) begin
      in_valid = n[0];
      data_in  = rand128();
      @(negedge clk);
      check("busy_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Random keys, plaintexts, gaps and output stalls.
    for (int i = 0; i < 12; i++) begin
      set_key(rand128());
      pt = rand128();
      out_ready = $urandom_range(0, 1) != 0;
      repeat ($urandom_range(0, 3)) tick();
      send(encrypt(pt), pt, 1'b1, a, w);
      in_valid = 1'b0;
      repeat (10 + $urandom_range(0, 6)) tick();
      out_ready = 1'b1;
      drain();
    end

    if (exp_q.size() != 0) flag("leftover_expectations");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_inv_cipher_seq.md
# aes_inv_cipher_seq

Iterative AES-128 inverse-cipher sequencer. Accepts one 128-bit ciphertext block over a valid/ready handshake, applies the initial AddRoundKey and one inverse round per clock (InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns, with InvMixColumns omitted in the final round), and presents the plaintext on a valid/ready output. Round keys come from the external key-schedule store, indexed by this block. It sits between the UART/JTAG bridge's block buffer and the result FIFO.

## Interface
- NumRounds, 10, inverse rounds per block. Only 10 (AES-128) is supported.
- Clk  input  1  system clock; all state changes on rising edge
- Rst  input  1  synchronous, active-high reset
- InValid  input  1  DataIn holds a ciphertext block
- InReady  output  1  block accepts DataIn this cycle
- DataIn  input  128  ciphertext; byte 0 in [127:120]; column-major state
- KeyValid  input  1  key store holds a complete expanded schedule
- KeyIdx  output  4  round-key index requested
- RoundKey  input  128  round key for KeyIdx; combinational, same cycle
- OutValid  output  1  DataOut holds plaintext
- OutReady  input  1  consumer accepts DataOut
- DataOut  output  128  plaintext; same byte order as DataIn
- Busy  output  1  high in ROUND or DONE

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - KeyIdx = NumRounds.
  - InReady = KeyValid.
  - On InValid && InReady: State ← DataIn ^ RoundKey, Round ← NumRounds-1, go to ROUND.
- ROUND:
  - KeyIdx = Round.
  - Round > 0: State ← InvMixColumns(InvSubBytes(InvShiftRows(State)) ^ RoundKey), Round ← Round-1.
  - Round == 0: State ← InvSubBytes(InvShiftRows(State)) ^ RoundKey, go to DONE.
- DONE:
  - OutValid = 1, DataOut = State, KeyIdx = 0.
  - On OutReady: go to IDLE.
- InReady = 0 outside IDLE. Only one block is in flight; no overlap.
- KeyValid is sampled only in IDLE. The key store must not change the schedule while Busy. The block does not check this.
- Round counter is 4 bits unsigned and never wraps; it leaves ROUND at 0.
- DataOut is registered State in every state. It is only meaningful while OutValid.

## Timing
- Reset values: state IDLE, State 0, Round 0, InReady 0, OutValid 0, Busy 0, DataOut 0, KeyIdx = NumRounds.
- Latency: accept edge at cycle 0; ROUND occupies cycles 1–10; OutValid rises in cycle 11.
- Throughput: 12 cycles per block when OutReady is held high (IDLE accept, 10 ROUND, 1 DONE).
- OutValid stays high and DataOut stays stable until OutReady. Backpressure lasts indefinitely without data loss.
- InValid while busy: no effect. The input block is held by the producer.
- InValid && !KeyValid in IDLE: not accepted; the block waits.
- Rst asserted in any state: next edge returns IDLE with reset values. An in-flight block is discarded and no OutValid is produced for it.
- Datapath critical path: one full inverse round plus the 128-bit XOR, single cycle.

## Structure
- Package aes_pkg:
  - typedef aes_state_t (logic [127:0])
  - state enum aes_seq_state_e {IDLE, ROUND, DONE}
  - constant AES_NR = 10
  - KeyIdx width constant = 4
- Sub-module aes_inv_round: combinational, input State, RoundKey, LastRound; output next State.
  - Instantiates the existing InvShiftRows, InvSubBytes and InvMixColumns.
  - Bypasses InvMixColumns when LastRound is high.
- The sequencer itself holds the FSM, Round counter, State register and handshakes only.

## Test plan
- FIPS-197 C.1: schedule expanded from key 000102030405060708090a0b0c0d0e0f, KeyValid = 1; send ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → DataOut 00112233445566778899aabbccddeeff with OutValid in cycle 11. KeyIdx sequence is 10, 9, …, 0.
- Same key; OutReady held low for 20 cycles after OutValid → OutValid and DataOut stay stable, InReady stays 0, then one transfer and return to IDLE.
- Three back-to-back blocks with InValid and OutReady held high → three correct outputs, InReady pulses exactly every 12 cycles.
- KeyValid = 0 with InValid = 1 for 5 cycles → no accept, Busy = 0. Raising KeyValid → accept on that cycle.
- Rst pulsed in ROUND cycle 5 → IDLE next cycle, all outputs at reset values, no OutValid. The next block decrypts correctly.
- InValid toggled with new data during ROUND → ignored; the in-flight result is unchanged.
